// File: rtl/fw_rule_matcher_if.sv
// Parsed header bus from the nibble packet parser into the firewall matcher.
// The parser side drives, the matcher side listens.
interface fw_rule_matcher_if;
  logic        p_ready;
  logic [1:0]  p_frame;
  logic [15:0] p_ethproto;
  logic [7:0]  p_ipproto;
  logic [31:0] p_srcip;
  logic [31:0] p_dstip;
  logic [15:0] p_srcport;
  logic [15:0] p_dstport;
  logic        p_frag;

  modport master (
    output p_ready, p_frame, p_ethproto,
    output p_ipproto, p_srcip, p_dstip,
    output p_srcport, p_dstport, p_frag
  );

  modport slave (
    input p_ready, p_frame, p_ethproto,
    input p_ipproto, p_srcip, p_dstip,
    input p_srcport, p_dstport, p_frag
  );
endinterface

// File: rtl/fw_rule_matcher.sv
// Firewall verdict stage: scans a rule table one entry per clock,
// first match wins, and keeps packet/drop statistics.
module fw_rule_matcher #(
  parameter int NRULES      = 16,
  parameter bit DEFAULT_ACT = 1'b0,
  parameter bit NONIP_ACT   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  fw_rule_matcher_if.slave p,
  input  logic         cfg_we,
  input  logic [5:0]   cfg_addr,
  input  logic [118:0] cfg_wdata,
  output logic         cfg_err,
  output logic         busy,
  output logic         verdict_vld,
  output logic         permit,
  output logic         hit,
  output logic [5:0]   hit_idx,
  output logic [31:0]  pkt_cnt,
  output logic [31:0]  drop_cnt,
  output logic         overrun
);

  localparam int IW = (NRULES > 1) ? $clog2(NRULES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NRULES - 1);

  typedef struct packed {
    logic        valid;
    logic        action;
    logic        proto_any;
    logic [7:0]  proto;
    logic [31:0] srcip;
    logic [5:0]  srcpfx;
    logic [31:0] dstip;
    logic [5:0]  dstpfx;
    logic [15:0] port_lo;
    logic [15:0] port_hi;
  } rule_t;

  typedef struct packed {
    logic [1:0]  frame;
    logic [15:0] ethproto;
    logic [7:0]  ipproto;
    logic [31:0] srcip;
    logic [31:0] dstip;
    logic [15:0] srcport;
    logic [15:0] dstport;
    logic        frag;
  } hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  rule_t         rules [NRULES];
  rule_t         cur;
  hdr_t          hdr;
  logic [IW-1:0] idx;
  logic          ready_q;
  logic          start;
  logic          non_ip;
  logic          last;
  logic          addr_ok;
  logic          l4;
  logic          proto_ok;
  logic          src_ok;
  logic          dst_ok;
  logic          port_ok;
  logic          match;
  logic          unused_dbg;

  function automatic logic [31:0] pfx_mask(
    input logic [5:0] pfx
  );
    logic [5:0] n;
    n = (pfx > 6'd32) ? 6'd32 : pfx;
    return (n == 6'd0) ? 32'd0
         : (32'hFFFF_FFFF << (6'd32 - n));
  endfunction

  assign start   = p.p_ready & ~ready_q;
  assign non_ip  = (p.p_frame != 2'b00)
                 | (p.p_ethproto != 16'h0800);
  assign last    = (idx == LAST);
  assign addr_ok = ({26'd0, cfg_addr} < 32'(NRULES));

  // Frame type, ethertype and source port are kept for debug visibility.
  assign unused_dbg = ^{hdr.frame, hdr.ethproto, hdr.srcport};

  always_comb begin
    cur      = rules[idx];
    proto_ok = cur.proto_any | (cur.proto == hdr.ipproto);
    src_ok   = ((hdr.srcip ^ cur.srcip)
               & pfx_mask(cur.srcpfx)) == 32'd0;
    dst_ok   = ((hdr.dstip ^ cur.dstip)
               & pfx_mask(cur.dstpfx)) == 32'd0;
    l4       = (hdr.ipproto == 8'd6)
             | (hdr.ipproto == 8'd17);
    port_ok  = 1'b1;
    if (l4) begin
      if (hdr.frag)
        port_ok = (cur.port_lo == 16'h0000)
                & (cur.port_hi == 16'hFFFF);
      else
        port_ok = (cur.port_lo <= hdr.dstport)
                & (hdr.dstport <= cur.port_hi);
    end
    match = cur.valid & proto_ok & src_ok
          & dst_ok & port_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)
              state_nx = non_ip ? DONE : SCAN;
      SCAN: if (match || last)
              state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    verdict_vld = (state == DONE);
  end

  // Writes land only while idle, so a scan never sees a half-updated table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NRULES; i++)
        rules[i] <= '0;
    end else if (cfg_we && !busy && addr_ok) begin
      rules[cfg_addr[IW-1:0]] <= rule_t'(cfg_wdata);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      hdr      <= '0;
      idx      <= '0;
      permit   <= 1'b0;
      hit      <= 1'b0;
      hit_idx  <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      overrun  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      ready_q <= p.p_ready;
      cfg_err <= cfg_we & busy;
      if (start && busy)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            hdr <= {p.p_frame, p.p_ethproto,
                    p.p_ipproto, p.p_srcip,
                    p.p_dstip, p.p_srcport,
                    p.p_dstport, p.p_frag};
            idx <= '0;
            if (non_ip) begin
              permit  <= NONIP_ACT;
              hit     <= 1'b0;
              hit_idx <= '0;
            end
          end
        end
        SCAN: begin
          if (match) begin
            permit  <= cur.action;
            hit     <= 1'b1;
            hit_idx <= 6'(idx);
          end else if (last) begin
            permit  <= DEFAULT_ACT;
            hit     <= 1'b0;
            hit_idx <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          pkt_cnt <= pkt_cnt + 32'd1;
          if (!permit)
            drop_cnt <= drop_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_rule_matcher.sv
// Randomised bench for fw_rule_matcher against a rule-level reference model.
// Verdict tuple = {latency[7:0], permit, hit, hit_idx[5:0], vld_next_cycle}.
module tb_fw_rule_matcher;
  localparam int NR  = 16;
  localparam bit DEF = 1'b0;
  localparam bit NIP = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_we;
  logic [5:0]   cfg_addr;
  logic [118:0] cfg_wdata;
  logic         cfg_err, busy, verdict_vld;
  logic         permit, hit, overrun;
  logic [5:0]   hit_idx;
  logic [31:0]  pkt_cnt, drop_cnt;

  fw_rule_matcher_if pif();

  fw_rule_matcher #(
    .NRULES(NR), .DEFAULT_ACT(DEF), .NONIP_ACT(NIP)
  ) dut (
    .clk(clk), .reset(reset), .p(pif),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .busy(busy), .verdict_vld(verdict_vld),
    .permit(permit), .hit(hit), .hit_idx(hit_idx),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_pkt, exp_drop;

  bit          m_valid [NR];
  bit          m_act [NR];
  bit          m_any [NR];
  logic [7:0]  m_proto [NR];
  logic [31:0] m_src [NR];
  logic [31:0] m_dst [NR];
  int          m_spfx [NR];
  int          m_dpfx [NR];
  int          m_lo [NR];
  int          m_hi [NR];

  logic [1:0]  h_frame;
  logic [15:0] h_eth;
  logic [7:0]  h_proto;
  logic [31:0] h_src, h_dst;
  logic [15:0] h_dport;
  logic        h_frag;

  task automatic clear_model();
    for (int k = 0; k < NR; k++) begin
      m_valid[k] = 0; m_act[k] = 0; m_any[k] = 0;
      m_proto[k] = 0; m_src[k] = 0; m_dst[k] = 0;
      m_spfx[k] = 0; m_dpfx[k] = 0;
      m_lo[k] = 0; m_hi[k] = 0;
    end
    exp_pkt = 0;
    exp_drop = 0;
  endtask

  function automatic bit pfx_ok(input logic [31:0] a,
                                input logic [31:0] b,
                                input int p);
    int q;
    q = (p > 32) ? 32 : p;
    if (q == 0) return 1'b1;
    return (a >> (32 - q)) == (b >> (32 - q));
  endfunction

  function automatic bit rule_hits(input int k);
    int dp;
    dp = int'(h_dport);
    if (!m_valid[k]) return 1'b0;
    if (!m_any[k] && m_proto[k] != h_proto) return 1'b0;
    if (!pfx_ok(h_src, m_src[k], m_spfx[k])) return 1'b0;
    if (!pfx_ok(h_dst, m_dst[k], m_dpfx[k])) return 1'b0;
    if (h_proto != 8'd6 && h_proto != 8'd17) return 1'b1;
    if (h_frag) return m_lo[k] == 0 && m_hi[k] == 65535;
    return m_lo[k] <= dp && dp <= m_hi[k];
  endfunction

  task automatic predict(output logic [16:0] ev);
    bit perm, ht;
    int idx, lat;
    perm = DEF; ht = 0; idx = 0; lat = 1 + NR;
    if (h_frame != 2'b00 || h_eth != 16'h0800) begin
      perm = NIP; lat = 1;
    end else begin
      for (int k = 0; k < NR; k++)
        if (rule_hits(k)) begin
          perm = m_act[k]; ht = 1; idx = k; lat = 2 + k;
          break;
        end
    end
    exp_pkt++;
    if (!perm) exp_drop++;
    ev = {lat[7:0], perm, ht, idx[5:0], 1'b0};
  endtask

  task automatic set_hdr(input logic [1:0] fr, input logic [15:0] et,
                         input logic [7:0] pr, input logic [31:0] s,
                         input logic [31:0] d, input logic [15:0] dp,
                         input logic fg);
    h_frame = fr; h_eth = et; h_proto = pr;
    h_src = s; h_dst = d; h_dport = dp; h_frag = fg;
  endtask

  task automatic drive_hdr();
    pif.p_frame = h_frame; pif.p_ethproto = h_eth;
    pif.p_ipproto = h_proto; pif.p_srcip = h_src;
    pif.p_dstip = h_dst; pif.p_dstport = h_dport;
    pif.p_frag = h_frag; pif.p_srcport = 16'($urandom);
  endtask

  task automatic write_rule(input int addr, input bit v, input bit a,
                            input bit any, input logic [7:0] pr,
                            input logic [31:0] s, input int sp,
                            input logic [31:0] d, input int dp,
                            input int lo, input int hi);
    @(posedge clk); #1;
    cfg_we = 1'b1;
    cfg_addr = addr[5:0];
    cfg_wdata = {v, a, any, pr, s, sp[5:0], d, dp[5:0],
                 lo[15:0], hi[15:0]};
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < NR) begin
      m_valid[addr] = v; m_act[addr] = a; m_any[addr] = any;
      m_proto[addr] = pr; m_src[addr] = s; m_dst[addr] = d;
      m_spfx[addr] = sp & 63; m_dpfx[addr] = dp & 63;
      m_lo[addr] = lo & 16'hFFFF; m_hi[addr] = hi & 16'hFFFF;
    end
  endtask

  task automatic run_pkt(output logic [16:0] ov,
                         output logic [63:0] oc);
    int lat;
    bit pm, ht;
    logic [5:0] ix;
    logic after;
    @(posedge clk); #1;
    drive_hdr();
    pif.p_ready = 1'b1;
    lat = 255; pm = 0; ht = 0; ix = 0;
    for (int n = 0; n < NR + 8; n++) begin
      @(negedge clk);
      if (verdict_vld) begin
        lat = n; pm = permit; ht = hit; ix = hit_idx;
        break;
      end
      @(posedge clk); #1;
      pif.p_ready = 1'b0;
    end
    pif.p_ready = 1'b0;
    @(negedge clk);
    after = verdict_vld;
    ov = {lat[7:0], pm, ht, ix, after};
    oc = {pkt_cnt, drop_cnt};
  endtask

  function automatic logic [31:0] rnd_ip();
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0: b = 32'h0A00_0000;
      1: b = 32'h0A01_0000;
      2: b = 32'hC0A8_0100;
      default: b = 32'hAC10_0000;
    endcase
    return b | {24'd0, 8'($urandom_range(0, 3))};
  endfunction

  function automatic logic [7:0] rnd_proto();
    case ($urandom_range(0, 2))
      0: return 8'd1;
      1: return 8'd6;
      default: return 8'd17;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({cfg_err, busy, verdict_vld, permit, hit, hit_idx,
         pkt_cnt, drop_cnt, overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got pkt=%0d drop=%0d busy=%b permit=%b required all 0",
               pkt_cnt, drop_cnt, busy, permit);
    end
  endtask

  task automatic test_empty();
    logic [16:0] ev, ov;
    logic [63:0] oc;
    set_hdr(2'b00, 16'h0800, 8'd6, 32'h0102_0304,
            32'h0506_0708, 16'd80, 1'b0);
    predict(ev);
    run_pkt(ov, oc);
    n_cmp++;
    if (ov !== ev) begin
      n_bad++;
      $display("FAIL empty_table verdict got %h required %h", ov, ev);
    end
    n_cmp++;
    if (oc !== {exp_pkt, exp_drop}) begin
      n_bad++;
      $display("FAIL empty_table counters got %h required %h",
               oc, {exp_pkt, exp_drop});
    end
  endtask

  task automatic test_overrun();
    int vcnt, vat, ecnt, eat;
    logic [16:0] ev, ov;
    logic [63:0] oc;
    set_hdr(2'b00, 16'h0800, 8'd6, 32'h0101_0101,
            32'h0202_0202, 16'd80, 1'b0);
    predict(ev);
    vcnt = 0; vat = -1; ecnt = 0; eat = -1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive_hdr(); pif.p_ready = 1'b1; end
        1: pif.p_ready = 1'b0;
        2: begin
          pif.p_ready = 1'b1;
          cfg_we = 1'b1; cfg_addr = 6'd2;
          cfg_wdata = {1'b1, 1'b1, 1'b1, 8'd0, 32'd0, 6'd0,
                       32'd0, 6'd0, 16'd0, 16'hFFFF};
        end
        3: begin pif.p_ready = 1'b0; cfg_we = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
      if (verdict_vld) begin vcnt++; vat = c; end
      if (cfg_err) begin ecnt++; eat = c; end
    end
    n_cmp++;
    if (vcnt !== 1 || vat !== int'(ev[16:9])) begin
      n_bad++;
      $display("FAIL overrun_verdicts got %0d at %0d required 1 at %0d",
               vcnt, vat, ev[16:9]);
    end
    n_cmp++;
    if (ecnt !== 1 || eat !== 3) begin
      n_bad++;
      $display("FAIL cfg_err_pulse got %0d at %0d required 1 at 3",
               ecnt, eat);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_flag got %b required 1", overrun);
    end
    n_cmp++;
    if ({pkt_cnt, drop_cnt} !== {exp_pkt, exp_drop}) begin
      n_bad++;
      $display("FAIL overrun_counters got %0d/%0d required %0d/%0d",
               pkt_cnt, drop_cnt, exp_pkt, exp_drop);
    end
    predict(ev);
    run_pkt(ov, oc);
    n_cmp++;
    if (ov !== ev) begin
      n_bad++;
      $display("FAIL busy_write_ignored verdict got %h required %h", ov, ev);
    end
  endtask

  task automatic test_mid_reset();
    int vcnt;
    logic [47:0] snap;
    logic [16:0] ev, ov;
    logic [63:0] oc;
    set_hdr(2'b00, 16'h0800, 8'd17, 32'h0303_0303,
            32'h0404_0404, 16'd53, 1'b0);
    vcnt = 0; snap = '1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive_hdr(); pif.p_ready = 1'b1; end
        1: pif.p_ready = 1'b0;
        3: reset = 1'b1;
        4: reset = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (verdict_vld) vcnt++;
      if (c == 3)
        snap = {busy, verdict_vld, permit, hit, overrun, cfg_err,
                hit_idx, pkt_cnt, 4'h0};
    end
    n_cmp++;
    if (vcnt !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_verdict got %0d pulses required 0", vcnt);
    end
    n_cmp++;
    if (snap !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got %h required 0", snap);
    end
    clear_model();
    predict(ev);
    run_pkt(ov, oc);
    n_cmp++;
    if (ov !== ev || oc !== {exp_pkt, exp_drop}) begin
      n_bad++;
      $display("FAIL post_reset_pkt got %h/%h required %h/%h",
               ov, oc, ev, {exp_pkt, exp_drop});
    end
  endtask

  task automatic test_prefix();
    logic [31:0] dst [2] = '{32'h0A01_0203, 32'h0B00_0001};
    logic [16:0] ev, ov;
    logic [63:0] oc;
    write_rule(3, 1, 0, 0, 8'd0, 32'd0, 0,
               32'h0A00_0000, 8, 0, 65535);
    write_rule(5, 1, 1, 1, 8'd0, 32'd0, 0,
               32'd0, 0, 0, 65535);
    for (int i = 0; i < 2; i++) begin
      set_hdr(2'b00, 16'h0800, 8'd6, 32'h0505_0505,
              dst[i], 16'd443, 1'b0);
      predict(ev);
      run_pkt(ov, oc);
      n_cmp++;
      if (ov !== ev) begin
        n_bad++;
        $display("FAIL prefix[%0d] verdict got %h required %h", i, ov, ev);
      end
      n_cmp++;
      if (oc !== {exp_pkt, exp_drop}) begin
        n_bad++;
        $display("FAIL prefix[%0d] counters got %h required %h",
                 i, oc, {exp_pkt, exp_drop});
      end
    end
  endtask

  task automatic test_ports();
    logic [7:0]  pr [5] = '{8'd6, 8'd6, 8'd6, 8'd1, 8'd17};
    logic [31:0] sr [5] = '{32'h0101_0101, 32'h0101_0101,
                            32'h0101_0101, 32'hC0A8_0304,
                            32'h0101_0101};
    logic [15:0] dp [5] = '{16'd80, 16'd81, 16'd80, 16'd5, 16'd80};
    logic        fg [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [16:0] ev, ov;
    logic [63:0] oc;
    write_rule(0, 1, 1, 0, 8'd6, 32'd0, 0, 32'd0, 0, 80, 80);
    write_rule(1, 1, 1, 1, 8'd0, 32'hC0A8_0000, 16,
               32'd0, 0, 1000, 1000);
    write_rule(20, 1, 0, 1, 8'd0, 32'd0, 0, 32'd0, 0, 0, 65535);
    for (int i = 0; i < 5; i++) begin
      set_hdr(2'b00, 16'h0800, pr[i], sr[i],
              32'h0B00_0001, dp[i], fg[i]);
      predict(ev);
      run_pkt(ov, oc);
      n_cmp++;
      if (ov !== ev) begin
        n_bad++;
        $display("FAIL ports[%0d] verdict got %h required %h", i, ov, ev);
      end
      n_cmp++;
      if (oc !== {exp_pkt, exp_drop}) begin
        n_bad++;
        $display("FAIL ports[%0d] counters got %h required %h",
                 i, oc, {exp_pkt, exp_drop});
      end
    end
  endtask

  task automatic test_nonip();
    logic [1:0]  fr [3] = '{2'b00, 2'b01, 2'b11};
    logic [15:0] et [3] = '{16'h86DD, 16'h0800, 16'h0806};
    logic [16:0] ev, ov;
    logic [63:0] oc;
    for (int i = 0; i < 3; i++) begin
      set_hdr(fr[i], et[i], 8'd6, 32'h0A01_0203,
              32'h0A01_0203, 16'd80, 1'b0);
      predict(ev);
      run_pkt(ov, oc);
      n_cmp++;
      if (ov !== ev || oc !== {exp_pkt, exp_drop}) begin
        n_bad++;
        $display("FAIL nonip[%0d] got %h/%h required %h/%h",
                 i, ov, oc, ev, {exp_pkt, exp_drop});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] ev, ov;
    logic [63:0] oc;
    for (int i = 0; i < 6; i++) begin
      set_hdr(2'b00, (i % 2 == 0) ? 16'h86DD : 16'h0800,
              rnd_proto(), rnd_ip(), rnd_ip(),
              16'($urandom_range(0, 100)), 1'b0);
      predict(ev);
      run_pkt(ov, oc);
      n_cmp++;
      if (ov !== ev || oc !== {exp_pkt, exp_drop}) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got %h/%h required %h/%h",
                 i, ov, oc, ev, {exp_pkt, exp_drop});
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] ev, ov;
    logic [63:0] oc;
    bit wide;
    for (int r = 0; r < 24; r++) begin
      wide = ($urandom_range(0, 4) == 0);
      write_rule($urandom_range(0, 19),
                 $urandom_range(0, 9) < 8, 1'($urandom),
                 $urandom_range(0, 9) < 3, rnd_proto(),
                 rnd_ip(), $urandom_range(0, 40),
                 rnd_ip(), $urandom_range(0, 40),
                 wide ? 0 : $urandom_range(0, 60),
                 wide ? 65535 : $urandom_range(20, 100));
    end
    for (int i = 0; i < 40; i++) begin
      set_hdr(($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00,
              ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800,
              rnd_proto(), rnd_ip(), rnd_ip(),
              16'($urandom_range(0, 100)),
              $urandom_range(0, 7) == 0);
      predict(ev);
      run_pkt(ov, oc);
      n_cmp++;
      if (ov !== ev || oc !== {exp_pkt, exp_drop}) begin
        n_bad++;
        $display("FAIL random[%0d] got %h/%h required %h/%h",
                 i, ov, oc, ev, {exp_pkt, exp_drop});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    pif.p_ready = 1'b0;
    pif.p_frame = '0;
    pif.p_ethproto = '0;
    pif.p_ipproto = '0;
    pif.p_srcip = '0;
    pif.p_dstip = '0;
    pif.p_srcport = '0;
    pif.p_dstport = '0;
    pif.p_frag = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_empty();
    test_overrun();
    test_mid_reset();
    test_prefix();
    test_ports();
    test_nonip();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
